sid_bus_master: RTL and testbench

SID_BUS_MASTER -- requirements
Module: sid_bus_master

---
 rtl/sid_bus_master_pkg.sv | 75 +++++++
 rtl/sid_bus_master_fifo.sv | 67 ++++++
 rtl/sid_bus_master.sv | 125 ++++++++++++
 tb/tb_sid_bus_master.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sid_bus_master_pkg.sv
// -----------------------------------------------------------------------------
// Package sid
// Shared types for the SID bus master:
//   reg5_t / reg8_t : SID register address and data widths
//   phase_t         : one-hot bus phase strobes, indexed by PHI2, PHI2_PHI1,
//                     PHI1, PHI1_PHI2
//   bus_op_e        : command operation (WRITE, READ, RESET)
//   bus_cmd_t       : queued command {op, wait_cnt, addr, data}
//   bus_i_t         : signals driven toward the SID bus interface
//   state_e         : bus master FSM states
// drive_bus() maps a command to the bus values presented during an access.
// -----------------------------------------------------------------------------
package sid;

    typedef logic [4:0] reg5_t;
    typedef logic [7:0] reg8_t;
    typedef logic [3:0] phase_t;

    localparam int PHI2      = 0;
    localparam int PHI2_PHI1 = 1;
    localparam int PHI1      = 2;
    localparam int PHI1_PHI2 = 3;

    typedef enum logic [1:0] {
        WRITE = 2'd0,
        READ  = 2'd1,
        RESET = 2'd2
    } bus_op_e;

    typedef struct packed {
        bus_op_e     op;
        logic [15:0] wait_cnt;
        reg5_t       addr;
        reg8_t       data;
    } bus_cmd_t;

    typedef struct packed {
        reg5_t addr;
        reg8_t data;
        logic  we;
        logic  oe;
        logic  res;
    } bus_i_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_ACCESS  = 2'd2,
        S_CAPTURE = 2'd3
    } state_e;

    // A RESET access drives only res; address and data stay at zero.
    function automatic bus_i_t drive_bus(bus_cmd_t c);
        bus_i_t b;
        b = '0;
        case (c.op)
            WRITE: begin
                b.addr = c.addr;
                b.data = c.data;
                b.we   = 1'b1;
            end
            READ: begin
                b.addr = c.addr;
                b.data = c.data;
                b.oe   = 1'b1;
            end
            RESET: begin
                b.res = 1'b1;
            end
            default: b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sid_bus_master_fifo.sv
// -----------------------------------------------------------------------------
// sid_cmd_fifo
// Synchronous command FIFO with registered occupancy count.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   push, din  : write request and command; ignored when full
//   pop        : read request; ignored when empty
//   dout       : head-of-queue command (valid while !empty)
//   empty/full : derived from the registered count
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sid_cmd_fifo
    import sid::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  bus_cmd_t din,
    input  logic     pop,
    output bus_cmd_t dout,
    output logic     empty,
    output logic     full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;
    bus_cmd_t      mem_q [DEPTH];

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only the count decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/sid_bus_master.sv
// -----------------------------------------------------------------------------
// sid_bus_master
// Queues SID bus commands and plays them out aligned to the SID bus phases.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   phase               : one-hot phase strobes (each high for one clk)
//   cmd_valid/cmd_ready : command handshake into the FIFO
//   cmd                 : {op, wait_cnt, addr, data}
//   bus_o               : addr/data/we/oe/res toward the SID, zero when idle
//   data_i              : read data from the SID
//   rsp_valid/rsp_data  : one-clk read response; rsp_data holds afterwards
//   busy                : FIFO non-empty or FSM not idle
// -----------------------------------------------------------------------------
module sid_bus_master
    import sid::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  phase_t   phase,
    input  logic     cmd_valid,
    output logic     cmd_ready,
    input  bus_cmd_t cmd,
    output bus_i_t   bus_o,
    input  reg8_t    data_i,
    output logic     rsp_valid,
    output reg8_t    rsp_data,
    output logic     busy
);

    state_e   state_q, state_d;
    bus_cmd_t cur_q, cur_d;
    reg8_t    rsp_data_q, rsp_data_d;
    logic     rdy_q, rdy_d;

    logic     fifo_push, fifo_pop, fifo_empty, fifo_full;
    bus_cmd_t fifo_dout;

    // The PHI1->PHI2 strobe carries no work for this master.
    logic     phase_unused;
    assign phase_unused = phase[PHI1_PHI2];

    // rdy_q holds cmd_ready low through reset and for the first clk after it.
    assign cmd_ready = rdy_q && !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;
    assign busy      = !fifo_empty || (state_q != S_IDLE);
    assign rsp_valid = (state_q == S_CAPTURE);
    assign rsp_data  = rsp_data_q;

    sid_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (cmd),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        rsp_data_d = rsp_data_q;
        rdy_d      = 1'b1;
        fifo_pop   = 1'b0;
        bus_o      = '0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cur_d    = fifo_dout;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                // wait_cnt doubles as the PHI2 down-counter.
                if (phase[PHI2]) begin
                    if (cur_q.wait_cnt == 16'd0) begin
                        state_d = S_ACCESS;
                    end else begin
                        cur_d.wait_cnt = cur_q.wait_cnt - 16'd1;
                    end
                end
            end
            S_ACCESS: begin
                bus_o = drive_bus(cur_q);
                if (phase[PHI1]) begin
                    state_d = S_IDLE;
                end else if (phase[PHI2_PHI1] && (cur_q.op == READ)) begin
                    rsp_data_d = data_i;
                    state_d    = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // Still inside the access window; return to ACCESS if PHI1
                // has not arrived yet so CAPTURE lasts exactly one clk.
                bus_o   = drive_bus(cur_q);
                state_d = phase[PHI1] ? S_IDLE : S_ACCESS;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rsp_data_q <= '0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rsp_data_q <= rsp_data_d;
            rdy_q      <= rdy_d;
        end
    end

    always_ff @(posedge clk) begin
        cur_q <= cur_d;
    end

endmodule

// File: tb/tb_sid_bus_master.sv
module tb_sid_bus_master;
    import sid::*;

    localparam int DEPTH = 4;

    logic     clk       = 1'b0;
    logic     rst_n     = 1'b0;
    phase_t   phase     = 4'b0001;
    logic     cmd_valid = 1'b0;
    bus_cmd_t cmd       = '0;
    reg8_t    data_i    = '0;
    logic     cmd_ready;
    bus_i_t   bus_o;
    logic     rsp_valid;
    reg8_t    rsp_data;
    logic     busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ph_idx = 0;

    bus_i_t exp_q[$];
    reg8_t  rsp_q[$];
    int     win_start[$];

    sid_bus_master #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .phase     (phase),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .bus_o     (bus_o),
        .data_i    (data_i),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Phase strobes rotate PHI2 -> PHI2_PHI1 -> PHI1 -> PHI1_PHI2, one per clk.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        ph_idx = (ph_idx + 1) % 4;
        phase  = phase_t'(4'b0001 << ph_idx);
    end

    initial begin
        #400000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bus_i_t model_bus(bus_cmd_t c);
        bus_i_t b;
        b = '0;
        if (c.op == WRITE) b = '{addr: c.addr, data: c.data, we: 1'b1, oe: 1'b0, res: 1'b0};
        if (c.op == READ)  b = '{addr: c.addr, data: c.data, we: 1'b0, oe: 1'b1, res: 1'b0};
        if (c.op == RESET) b = '{addr: 5'h0, data: 8'h0, we: 1'b0, oe: 1'b0, res: 1'b1};
        return b;
    endfunction

    function automatic bus_cmd_t mk(bus_op_e op, int w, reg5_t a, reg8_t d);
        bus_cmd_t c;
        c.op       = op;
        c.wait_cnt = 16'(w);
        c.addr     = a;
        c.data     = d;
        return c;
    endfunction

    // Scoreboard monitor: every access window is popped against exp_q and
    // every read response against rsp_q.
    bus_i_t cur_exp = '0;
    int     win_len = 0;
    logic   in_win  = 1'b0;
    logic   act;
    always @(negedge clk) begin
        act = bus_o.we | bus_o.oe | bus_o.res;
        if (!rst_n) begin
            in_win  = 1'b0;
            win_len = 0;
        end else begin
            if (act && !in_win) begin
                in_win  = 1'b1;
                win_len = 0;
                win_start.push_back(cyc);
                chk("win_start_phase", 32'(phase), 32'(4'b0010));
                chk("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
                cur_exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            end
            if (in_win) begin
                if (act) begin
                    win_len++;
                    chk("bus_o", 32'(bus_o), 32'(cur_exp));
                end else begin
                    chk("win_len", 32'(win_len), 32'd2);
                    in_win = 1'b0;
                end
            end
            if (rsp_valid) begin
                chk("rsp_has_entry", 32'(rsp_q.size() > 0), 32'd1);
                chk("rsp_in_2nd_cycle", 32'(win_len), 32'd2);
                if (rsp_q.size() > 0) chk("rsp_data", 32'(rsp_data), 32'(rsp_q.pop_front()));
            end
        end
    end

    task automatic push(input bus_cmd_t c, input reg8_t rexp);
        int g;
        g = 0;
        while (!cmd_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("push_ready", 32'(cmd_ready), 32'd1);
        cmd       = c;
        cmd_valid = 1'b1;
        exp_q.push_back(model_bus(c));
        if (c.op == READ) rsp_q.push_back(rexp);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Counts PHI2 strobes until the access window opens.
    task automatic wait_access(output int n_phi2, output bit ok);
        n_phi2 = 0;
        ok     = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus_o.we | bus_o.oe | bus_o.res) begin
                ok = 1'b1;
                break;
            end
            if (phase[PHI2]) n_phi2++;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle", 32'(busy), 32'd0);
    endtask

    bus_cmd_t burst[DEPTH+1];
    int       n;
    bit       ok;
    int       acc, g, ws;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_bus_o", 32'(bus_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_at_release", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("ready_after_release", 32'(cmd_ready), 32'd1);

        // Single write, no wait
        push(mk(WRITE, 0, 5'h18, 8'h0F), 8'h00);
        chk("busy_with_cmd", 32'(busy), 32'd1);
        wait_access(n, ok);
        chk("wr_found", 32'(ok), 32'd1);
        chk("wr_phi2_count", 32'(n), 32'd1);
        wait_idle();
        repeat (12) @(negedge clk);
        chk("wr_one_access", 32'(win_start.size()), 32'd1);

        // Read, response captured on PHI2_PHI1
        data_i = 8'hA5;
        push(mk(READ, 0, 5'h1B, 8'h00), 8'hA5);
        wait_access(n, ok);
        chk("rd_found", 32'(ok), 32'd1);
        chk("rd_phi2_count", 32'(n), 32'd1);
        wait_idle();
        chk("rd_rsp_seen", 32'(rsp_q.size()), 32'd0);
        data_i = 8'h00;

        // Write with wait 3
        push(mk(WRITE, 3, 5'h05, 8'h5A), 8'h00);
        wait_access(n, ok);
        chk("wait3_found", 32'(ok), 32'd1);
        chk("wait3_phi2_count", 32'(n), 32'd4);
        wait_idle();

        // RESET op
        push(mk(RESET, 0, 5'h1F, 8'hFF), 8'h00);
        wait_access(n, ok);
        chk("res_found", 32'(ok), 32'd1);
        chk("res_phi2_count", 32'(n), 32'd1);
        wait_idle();
        chk("rsp_data_hold", 32'(rsp_data), 32'hA5);

        // Burst of DEPTH+1 with cmd_valid held
        data_i = 8'h3C;
        for (int i = 0; i <= DEPTH; i++) begin
            burst[i] = mk((i == 2) ? READ : WRITE, 0, reg5_t'(i + 1), reg8_t'(8'h40 + i));
        end
        ws  = win_start.size();
        acc = 0;
        g   = 0;
        while (acc <= DEPTH && g < 50) begin
            if (cmd_ready) begin
                cmd       = burst[acc];
                cmd_valid = 1'b1;
                exp_q.push_back(model_bus(burst[acc]));
                if (burst[acc].op == READ) rsp_q.push_back(8'h3C);
                acc++;
            end
            g++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("burst_full_ready", 32'(cmd_ready), 32'd0);
        chk("burst_accepted", 32'(acc), 32'(DEPTH + 1));
        chk("burst_contiguous", 32'(g), 32'(DEPTH + 1));
        wait_idle();
        chk("burst_windows", 32'(win_start.size() - ws), 32'(DEPTH + 1));
        for (int k = ws + 1; k < win_start.size(); k++) begin
            chk("burst_gap", 32'(win_start[k] - win_start[k-1]), 32'd4);
        end
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        chk("rsp_empty", 32'(rsp_q.size()), 32'd0);
        chk("rsp_data_burst", 32'(rsp_data), 32'h3C);

        // Reset during a write access with commands still queued
        push(mk(WRITE, 0, 5'h0A, 8'h11), 8'h00);
        push(mk(WRITE, 0, 5'h0B, 8'h22), 8'h00);
        push(mk(WRITE, 0, 5'h0C, 8'h33), 8'h00);
        wait_access(n, ok);
        chk("rst_mid_found", 32'(ok), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_bus_o", 32'(bus_o), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_ready", 32'(cmd_ready), 32'd0);
        exp_q.delete();
        rsp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ws = win_start.size();
        repeat (40) @(negedge clk);
        chk("rst_no_more_access", 32'(win_start.size() - ws), 32'd0);
        chk("rst_after_busy", 32'(busy), 32'd0);
        chk("rst_after_bus_o", 32'(bus_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
